timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel programmable timer: NUM_CH independent down-counters, each with its own prescaler, reload, compare and mode (off, one-shot, periodic, PWM). It is the next generation of the team's single-channel timer, adding channel count, width/prescaler generics, per-channel interrupts and PWM duty control. It sits on the peripheral side behind a simple register-write port and drives interrupt and PWM pins.

## Interface
- NUM_CH, 4, number of timer channels (≥1)
- WIDTH, 16, counter/reload/compare width in bits
- PRESC_W, 8, prescaler width; tick divides clk by cfg_presc+1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  write cfg_* fields to channel cfg_ch this cycle
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel for cfg_we
- cfg_mode  in  2  timer_mode: OFF, ONE_SHORT, PERIODIC, PWM
- cfg_reload  in  WIDTH  reload value R
- cfg_compare  in  WIDTH  PWM compare value C
- cfg_presc  in  PRESC_W  prescaler value P
- start  in  NUM_CH  per-channel start pulse
- stop  in  NUM_CH  per-channel stop pulse
- irq_clr  in  NUM_CH  per-channel interrupt clear
- count  out  NUM_CH*WIDTH  packed current counts, channel 0 in LSBs
- active  out  NUM_CH  channel running
- irq  out  NUM_CH  sticky interrupt flags
- pwm_out  out  NUM_CH  PWM outputs

## Operation
- Reset: all config registers, count, prescaler counters, active, irq = 0; pwm_out = 0.
- cfg_we: updates mode/R/C/P of channel cfg_ch at the clock edge; cfg_ch ≥ NUM_CH ignored. Running channel: new R used at next reload, new C/P used immediately, count not reloaded. Writing mode OFF to an active channel clears active at that edge.
- start[i] (mode ≠ OFF): count←R, presc_cnt←0, active←1. start while active restarts. start with mode OFF ignored.
- stop[i]: active←0, count holds. stop and start same cycle: stop wins.
- Tick: while active, presc_cnt increments each cycle; when presc_cnt == P, tick fires and presc_cnt←0.
- On tick, count ≠ 0: count←count−1.
- On tick, count == 0: irq[i]←1 and
  - ONE_SHORT: active←0, count stays 0.
  - PERIODIC / PWM: count←R, keep running.
- irq sticky until irq_clr[i]; set and clear same cycle: set wins.
- pwm_out[i] = active[i] & (mode==PWM) & (count[i] < C), combinational from registers. C=0 → always low; C > R → always high while active.
- Arithmetic unsigned; no wrap below 0 (count==0 is terminal/reload point).

## Timing
- start sampled at edge E → count=R, active=1 visible after E.
- irq rises after edge E + (R+1)(P+1); ONE_SHORT active falls on the same edge.
- PERIODIC/PWM period = (R+1)(P+1) cycles; PWM high time = min(C, R+1)·(P+1) cycles per period.
- R=0, P=0: irq every cycle in PERIODIC; ONE_SHORT fires one edge after load.
- Config write latency: one edge. stop/irq_clr latency: one edge.
- Reset mid-operation: all outputs drop to 0 immediately (asynchronous).

## Structure
- Shared package: reuse existing timer_mode enum; add packed struct timer_cfg_t {mode, reload, compare, presc} and per-channel parameters via package-level localparam defaults.
- Sub-module timer_channel (one counter, prescaler, mode FSM, irq, pwm) instantiated NUM_CH times in a generate loop; timer_bank does cfg_ch decode and output packing.

## Test plan
- Reset: assert rst_n=0 mid-count → count, active, irq, pwm_out all 0 same cycle.
- ONE_SHORT ch0, R=5, P=0: start → irq[0] rises exactly 6 edges after load, active[0] falls, count stays 0; irq_clr clears it.
- PERIODIC ch1, R=3, P=2: irq every 12 cycles; irq_clr on the same cycle as a terminal tick → irq stays 1.
- PWM ch2, R=9, C=3, P=0: pwm_out high 3 of every 10 cycles; C=0 → constant low; C=15 → constant high.
- Simultaneous start[3] and stop[3] → active[3]=0; cfg_we to ch3 with mode OFF while running → stops next edge.
- Mid-run write R=7 on PERIODIC channel with R=2 → current period completes at 3 ticks, next period 8 ticks; cfg_ch out of range has no effect (NUM_CH=3 build).

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared types and defaults for the multi-channel timer bank.
// The mode encoding is shared with the single-channel timer.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_ONE_SHOT = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_PWM      = 2'd3
    } timer_mode_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_PRESC_W = 8;

    // Channel configuration at the default geometry.
    typedef struct packed {
        timer_mode_t            mode;
        logic [DEF_WIDTH-1:0]   reload;
        logic [DEF_WIDTH-1:0]   compare;
        logic [DEF_PRESC_W-1:0] presc;
    } timer_cfg_t;

    // Channel-select width; a single-channel bank still has a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Configuration write port of the timer bank: one channel's fields per write.
interface timer_bank_if
    import timer_bank_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) ();

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    timer_mode_t        cfg_mode;
    logic [WIDTH-1:0]   cfg_reload;
    logic [WIDTH-1:0]   cfg_compare;
    logic [PRESC_W-1:0] cfg_presc;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_reload, cfg_compare, cfg_presc
    );

    modport slave (
        input cfg_we, cfg_ch, cfg_mode, cfg_reload, cfg_compare, cfg_presc
    );

endinterface

// File: rtl/timer_bank_channel.sv
// One timer channel: prescaler, down-counter, mode control, sticky irq and PWM.
// Priority on an edge: stop / write-OFF, then start, then normal counting.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  timer_mode_t        cfg_mode,
    input  logic [WIDTH-1:0]   cfg_reload,
    input  logic [WIDTH-1:0]   cfg_compare,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic               start,
    input  logic               stop,
    input  logic               irq_clr,
    output logic [WIDTH-1:0]   count,
    output logic               active,
    output logic               irq,
    output logic               pwm_out
);

    timer_mode_t        mode;
    logic [WIDTH-1:0]   reload;
    logic [WIDTH-1:0]   compare;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;

    logic off_wr;
    logic do_start;
    logic tick;
    logic expire;

    // ">=" lets a shrinking prescale value take effect without wrapping presc_cnt.
    always_comb begin
        off_wr   = cfg_we && (cfg_mode == MODE_OFF);
        do_start = start && (mode != MODE_OFF);
        tick     = active && (presc_cnt >= presc);
        expire   = tick && (count == '0) && !stop && !off_wr && !do_start;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode      <= MODE_OFF;
            reload    <= '0;
            compare   <= '0;
            presc     <= '0;
            presc_cnt <= '0;
            count     <= '0;
            active    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (cfg_we) begin
                mode    <= cfg_mode;
                reload  <= cfg_reload;
                compare <= cfg_compare;
                presc   <= cfg_presc;
            end

            if (stop || off_wr) begin
                active <= 1'b0;
            end else if (do_start) begin
                count     <= reload;
                presc_cnt <= '0;
                active    <= 1'b1;
            end else if (active) begin
                if (tick) begin
                    presc_cnt <= '0;
                    if (count != '0)
                        count <= count - WIDTH'(1);
                    else if (mode == MODE_ONE_SHOT)
                        active <= 1'b0;
                    else
                        count <= reload;
                end else begin
                    presc_cnt <= presc_cnt + PRESC_W'(1);
                end
            end

            if (expire)
                irq <= 1'b1;
            else if (irq_clr)
                irq <= 1'b0;
        end
    end

    assign pwm_out = active && (mode == MODE_PWM) && (count < compare);

endmodule

// File: rtl/timer_bank.sv
// Multi-channel programmable timer: decodes the config port per channel and
// packs the channel outputs (channel 0 in the LSBs).
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    timer_bank_if.slave             bus,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       irq_clr,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       active,
    output logic [NUM_CH-1:0]       irq,
    output logic [NUM_CH-1:0]       pwm_out
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    // Select values at or above NUM_CH match no channel, so such writes drop.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        timer_channel #(
            .WIDTH   (WIDTH),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .cfg_we      (sel),
            .cfg_mode    (bus.cfg_mode),
            .cfg_reload  (bus.cfg_reload),
            .cfg_compare (bus.cfg_compare),
            .cfg_presc   (bus.cfg_presc),
            .start       (start[i]),
            .stop        (stop[i]),
            .irq_clr     (irq_clr[i]),
            .count       (count[i*WIDTH +: WIDTH]),
            .active      (active[i]),
            .irq         (irq[i]),
            .pwm_out     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: a 4-channel and a 3-channel instance.
// Stimulus queues expected channel states; a negedge monitor pops and compares.
module tb_timer_bank;
    import timer_bank_pkg::*;

    typedef struct {
        string name;
        int    dut;
        int    ch;
        int    cnt;   // -1: not compared
        int    act;
        int    irq;
        int    pwm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timer_bank_if #(.NUM_CH(4)) bus_a ();
    timer_bank_if #(.NUM_CH(3)) bus_b ();

    logic [3:0]  start_a, stop_a, clr_a, active_a, irq_a, pwm_a;
    logic [63:0] count_a;
    logic [2:0]  start_b, stop_b, clr_b, active_b, irq_b, pwm_b;
    logic [47:0] count_b;

    timer_bank #(.NUM_CH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .start(start_a), .stop(stop_a), .irq_clr(clr_a),
        .count(count_a), .active(active_a), .irq(irq_a), .pwm_out(pwm_a)
    );

    timer_bank #(.NUM_CH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .start(start_b), .stop(stop_b), .irq_clr(clr_b),
        .count(count_b), .active(active_b), .irq(irq_b), .pwm_out(pwm_b)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        start_a = '0; stop_a = '0; clr_a = '0;
        start_b = '0; stop_b = '0; clr_b = '0;
    endtask

    task automatic expect_ch(input string name, input int dut, input int ch,
                             input int cnt, input int act, input int irq, input int pwm);
        q.push_back('{name, dut, ch, cnt, act, irq, pwm});
    endtask

    function automatic timer_cfg_t mk_cfg(input timer_mode_t m, input int r, input int c, input int p);
        timer_cfg_t t;
        t.mode    = m;
        t.reload  = 16'(r);
        t.compare = 16'(c);
        t.presc   = 8'(p);
        return t;
    endfunction

    task automatic cfg_write(input int dut, input int ch, input timer_cfg_t c);
        if (dut == 0) begin
            bus_a.cfg_ch = 2'(ch); bus_a.cfg_mode = c.mode; bus_a.cfg_reload = c.reload;
            bus_a.cfg_compare = c.compare; bus_a.cfg_presc = c.presc; bus_a.cfg_we = 1'b1;
        end else begin
            bus_b.cfg_ch = 2'(ch); bus_b.cfg_mode = c.mode; bus_b.cfg_reload = c.reload;
            bus_b.cfg_compare = c.compare; bus_b.cfg_presc = c.presc; bus_b.cfg_we = 1'b1;
        end
        step();
        bus_a.cfg_we = 1'b0;
        bus_b.cfg_we = 1'b0;
    endtask

    // Monitor: compares every queued expectation against the DUT at the falling edge.
    initial begin : monitor
        exp_t e;
        int   c, a, i, p;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.dut == 0) begin
                    c = int'(count_a[e.ch*16 +: 16]);
                    a = int'(active_a[e.ch]); i = int'(irq_a[e.ch]); p = int'(pwm_a[e.ch]);
                end else begin
                    c = int'(count_b[e.ch*16 +: 16]);
                    a = int'(active_b[e.ch]); i = int'(irq_b[e.ch]); p = int'(pwm_b[e.ch]);
                end
                if (e.cnt >= 0) check({e.name, ".count"}, c, e.cnt);
                if (e.act >= 0) check({e.name, ".active"}, a, e.act);
                if (e.irq >= 0) check({e.name, ".irq"}, i, e.irq);
                if (e.pwm >= 0) check({e.name, ".pwm"}, p, e.pwm);
            end
        end
    end

    initial begin : stim
        int cnt;
        int irq_exp;
        clear_pulses();
        bus_a.cfg_we = 1'b0; bus_a.cfg_ch = '0; bus_a.cfg_mode = MODE_OFF;
        bus_a.cfg_reload = '0; bus_a.cfg_compare = '0; bus_a.cfg_presc = '0;
        bus_b.cfg_we = 1'b0; bus_b.cfg_ch = '0; bus_b.cfg_mode = MODE_OFF;
        bus_b.cfg_reload = '0; bus_b.cfg_compare = '0; bus_b.cfg_presc = '0;

        // Reset state
        step(); step();
        for (int ch = 0; ch < 4; ch++) expect_ch("reset_a", 0, ch, 0, 0, 0, 0);
        for (int ch = 0; ch < 3; ch++) expect_ch("reset_b", 1, ch, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();

        // One-shot: R=5, P=0 -> irq 6 edges after load, then idle at 0
        cfg_write(0, 0, mk_cfg(MODE_ONE_SHOT, 5, 0, 0));
        start_a[0] = 1'b1; step(); clear_pulses();
        expect_ch("os_load", 0, 0, 5, 1, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k < 6) expect_ch("os_run", 0, 0, 5 - k, 1, 0, 0);
            else       expect_ch("os_fire", 0, 0, 0, 0, 1, 0);
        end
        step();
        expect_ch("os_hold", 0, 0, 0, 0, 1, 0);
        clr_a[0] = 1'b1; step(); clear_pulses();
        expect_ch("os_clr", 0, 0, 0, 0, 0, 0);

        // Periodic: R=3, P=2 -> 12-cycle period; clear collides with set on k=24
        cfg_write(0, 1, mk_cfg(MODE_PERIODIC, 3, 0, 2));
        start_a[1] = 1'b1; step(); clear_pulses();
        expect_ch("per_load", 0, 1, 3, 1, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            if (k == 13 || k == 24) clr_a[1] = 1'b1;
            step(); clear_pulses();
            cnt     = (k % 12 == 0) ? 3 : 3 - (k % 12) / 3;
            irq_exp = (k == 12 || k == 24) ? 1 : 0;
            expect_ch("per_run", 0, 1, cnt, 1, irq_exp, 0);
        end
        stop_a[1] = 1'b1; clr_a[1] = 1'b1; step(); clear_pulses();
        expect_ch("per_stop", 0, 1, 3, 0, 0, 0);

        // PWM: R=9, C=3, P=0 -> high while count in {2,1,0}
        cfg_write(0, 2, mk_cfg(MODE_PWM, 9, 3, 0));
        start_a[2] = 1'b1; step(); clear_pulses();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step();
            cnt = 9 - (k % 10);
            expect_ch("pwm_c3", 0, 2, cnt, 1, (k >= 10) ? 1 : 0, (cnt < 3) ? 1 : 0);
        end
        cfg_write(0, 2, mk_cfg(MODE_PWM, 9, 0, 0));
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            expect_ch("pwm_c0", 0, 2, -1, 1, -1, 0);
        end
        cfg_write(0, 2, mk_cfg(MODE_PWM, 9, 15, 0));
        for (int k = 0; k < 10; k++) begin
            if (k > 0) step();
            expect_ch("pwm_c15", 0, 2, -1, 1, -1, 1);
        end
        stop_a[2] = 1'b1; step(); clear_pulses();
        expect_ch("pwm_stop", 0, 2, -1, 0, -1, 0);

        // Channel 3: start+stop together, then write-OFF while running
        cfg_write(0, 3, mk_cfg(MODE_PERIODIC, 4, 0, 0));
        start_a[3] = 1'b1; stop_a[3] = 1'b1; step(); clear_pulses();
        expect_ch("start_stop", 0, 3, 0, 0, 0, 0);
        start_a[3] = 1'b1; step(); clear_pulses();
        expect_ch("ch3_load", 0, 3, 4, 1, 0, 0);
        step();
        expect_ch("ch3_run", 0, 3, 3, 1, 0, 0);
        cfg_write(0, 3, mk_cfg(MODE_OFF, 4, 0, 0));
        expect_ch("ch3_off_wr", 0, 3, -1, 0, 0, 0);
        start_a[3] = 1'b1; step(); clear_pulses();
        expect_ch("ch3_start_off", 0, 3, -1, 0, 0, 0);

        // 3-channel bank: mid-run reload change, out-of-range writes
        cfg_write(1, 0, mk_cfg(MODE_PERIODIC, 2, 0, 0));
        start_b[0] = 1'b1; step(); clear_pulses();
        expect_ch("rl_load", 1, 0, 2, 1, 0, 0);
        cfg_write(1, 0, mk_cfg(MODE_PERIODIC, 7, 0, 0));
        expect_ch("rl_wr", 1, 0, 1, 1, 0, 0);
        step();
        expect_ch("rl_zero", 1, 0, 0, 1, 0, 0);
        step();
        expect_ch("rl_reload7", 1, 0, 7, 1, 1, 0);
        clr_b[0] = 1'b1; step(); clear_pulses();
        expect_ch("rl_clr", 1, 0, 6, 1, 0, 0);
        cfg_write(1, 3, mk_cfg(MODE_OFF, 1, 0, 0));
        expect_ch("oor_off", 1, 0, 5, 1, 0, 0);
        for (int k = 6; k <= 11; k++) begin
            step();
            expect_ch("rl_period8", 1, 0, (k == 11) ? 7 : 10 - k, 1, (k == 11) ? 1 : 0, 0);
        end
        cfg_write(1, 3, mk_cfg(MODE_PERIODIC, 1, 0, 0));
        expect_ch("oor_per", 1, 0, 6, 1, 1, 0);
        start_b = 3'b110; step(); clear_pulses();
        expect_ch("oor_ch1", 1, 1, 0, 0, 0, 0);
        expect_ch("oor_ch2", 1, 2, 0, 0, 0, 0);
        expect_ch("oor_ch0", 1, 0, 5, 1, 1, 0);

        // Asynchronous reset mid-operation
        start_a[2] = 1'b1; step(); clear_pulses();
        expect_ch("pre_rst", 0, 2, 9, 1, -1, 1);
        step();
        #2;
        rst_n = 1'b0;
        for (int ch = 0; ch < 4; ch++) expect_ch("async_rst_a", 0, ch, 0, 0, 0, 0);
        for (int ch = 0; ch < 3; ch++) expect_ch("async_rst_b", 1, ch, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
